decode_stage_pipe: RTL and testbench

//   Registered, handshaked successor to the combinational instruction decoder. Sits between fetch and

---
 rtl/decode_stage_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// Registered RV32I + custom-opcode decode stage between fetch and execute.
// A two-entry output/skid buffer holds decoded results, and load-use hazards insert a bubble.
module decode_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int EN_CUSTOM = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             dec_valid,
    output logic [XLEN-1:0]  dec_pc,
    output logic [31:0]      dec_instr,
    output logic [4:0]       dec_rd,
    output logic [4:0]       dec_rs1,
    output logic [4:0]       dec_rs2,
    output logic             dec_write_en,
    output logic             dec_rd_en,
    output logic             dec_wrt_en,
    output logic             dec_jalr,
    output logic             dec_lui,
    output logic             dec_auipc,
    output logic [3:0]       dec_alu_op,
    output logic [3:0]       dec_bj_inst,
    output logic [1:0]       dec_wb_sel,
    output logic [1:0]       dec_type_sel,
    output logic [1:0]       dec_width,
    output logic [7:0]       dec_custom,
    output logic             dec_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            write_en;
        logic            rd_en;
        logic            wrt_en;
        logic            jalr;
        logic            lui;
        logic            auipc;
        logic [3:0]      alu_op;
        logic [3:0]      bj_inst;
        logic [1:0]      wb_sel;
        logic [1:0]      type_sel;
        logic [1:0]      width;
        logic [7:0]      custom;
        logic            illegal;
        logic            is_ld;
    } dec_t;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic w_r, w_i, w_ld, w_st, w_br, w_jal, w_jalr, w_lui, w_auipc;
    logic w_c_rand, w_c_ppu, w_c_sac, w_c_uad, w_c_snd, w_c_rsi, w_c_rdi, w_c_rti;
    logic w_en_custom, w_use_rs1, w_use_rs2, w_hazard, w_accept, w_out_free;
    dec_t w_dec;

    dec_t             r_out;
    dec_t             r_skid;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_op        = if_instr[6:0];
    assign w_f3        = if_instr[14:12];
    assign w_en_custom = (EN_CUSTOM != 0);

    assign w_r     = (w_op == 7'b0110011);
    assign w_i     = (w_op == 7'b0010011);
    assign w_ld    = (w_op == 7'b0000011);
    assign w_st    = (w_op == 7'b0100011);
    assign w_br    = (w_op == 7'b1100011);
    assign w_jal   = (w_op == 7'b1101111);
    assign w_jalr  = (w_op == 7'b1100111);
    assign w_lui   = (w_op == 7'b0110111);
    assign w_auipc = (w_op == 7'b0010111);

    // Custom opcodes vanish entirely when disabled, so they fall through as illegal.
    assign w_c_rand = w_en_custom && (w_op == 7'b0101010);
    assign w_c_ppu  = w_en_custom && (w_op == 7'b0101000);
    assign w_c_sac  = w_en_custom && (w_op == 7'b0101001);
    assign w_c_uad  = w_en_custom && (w_op == 7'b0101011);
    assign w_c_snd  = w_en_custom && (w_op == 7'b0001011);
    assign w_c_rsi  = w_en_custom && (w_op == 7'b0001001);
    assign w_c_rdi  = w_en_custom && (w_op == 7'b0001010);
    assign w_c_rti  = w_en_custom && (w_op == 7'b0001000);

    always_comb begin
        w_dec          = '0;
        w_dec.pc       = if_pc;
        w_dec.instr    = if_instr;
        w_dec.rd       = if_instr[11:7];
        w_dec.rs1      = if_instr[19:15];
        w_dec.rs2      = if_instr[24:20];
        w_dec.write_en = w_r | w_i | w_ld | w_jal | w_jalr | w_lui | w_auipc | w_c_rand | w_c_rdi;
        w_dec.rd_en    = w_ld;
        w_dec.wrt_en   = w_st;
        w_dec.jalr     = w_jalr;
        w_dec.lui      = w_lui;
        w_dec.auipc    = w_auipc;
        w_dec.alu_op   = w_r ? {if_instr[30], w_f3} : {1'b0, w_f3};
        if (w_jal || w_jalr)
            w_dec.bj_inst = 4'b1011;
        else if (w_br)
            w_dec.bj_inst = {1'b1, w_f3};
        if ((w_ld && (w_f3 == 3'b000 || w_f3 == 3'b100)) || (w_st && w_f3 == 3'b000))
            w_dec.width = 2'd1;
        else if ((w_ld && (w_f3 == 3'b001 || w_f3 == 3'b101)) || (w_st && w_f3 == 3'b001))
            w_dec.width = 2'd2;
        if (w_c_sac)
            w_dec.wb_sel = 2'd0;
        else if (w_jal || w_jalr)
            w_dec.wb_sel = 2'd1;
        else if (w_ld || w_c_rand || w_c_rdi)
            w_dec.wb_sel = 2'd2;
        else
            w_dec.wb_sel = 2'd3;
        if (w_lui || w_auipc)
            w_dec.type_sel = 2'd2;
        else if (w_jal)
            w_dec.type_sel = 2'd3;
        else if (w_br)
            w_dec.type_sel = 2'd1;
        w_dec.custom  = {w_c_rand, w_c_ppu, w_c_rti, w_c_rsi, w_c_sac, w_c_snd, w_c_uad, w_c_rdi};
        w_dec.illegal = !(w_r | w_i | w_ld | w_st | w_br | w_jal | w_jalr | w_lui | w_auipc |
                          (|w_dec.custom));
        w_dec.is_ld   = w_ld;
    end

    // Only the output slot needs checking: a full skid already blocks intake.
    assign w_use_rs1 = w_r | w_i | w_ld | w_st | w_br | w_jalr | w_c_ppu | w_c_sac | w_c_snd | w_c_rsi;
    assign w_use_rs2 = w_r | w_st | w_br;
    assign w_hazard  = r_out_valid && r_out.is_ld && (r_out.rd != 5'd0) && if_valid &&
                       ((w_use_rs1 && (w_dec.rs1 == r_out.rd)) || (w_use_rs2 && (w_dec.rs2 == r_out.rd)));

    // Handshake: a word moves in when if_valid && if_ready and out when dec_valid && ex_ready.
    assign if_ready   = !rst && !r_skid_valid && !w_hazard;
    assign w_accept   = if_valid && if_ready;
    assign w_out_free = !r_out_valid || ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign dec_valid    = r_out_valid;
    assign dec_pc       = r_out.pc;
    assign dec_instr    = r_out.instr;
    assign dec_rd       = r_out.rd;
    assign dec_rs1      = r_out.rs1;
    assign dec_rs2      = r_out.rs2;
    assign dec_write_en = r_out.write_en;
    assign dec_rd_en    = r_out.rd_en;
    assign dec_wrt_en   = r_out.wrt_en;
    assign dec_jalr     = r_out.jalr;
    assign dec_lui      = r_out.lui;
    assign dec_auipc    = r_out.auipc;
    assign dec_alu_op   = r_out.alu_op;
    assign dec_bj_inst  = r_out.bj_inst;
    assign dec_wb_sel   = r_out.wb_sel;
    assign dec_type_sel = r_out.type_sel;
    assign dec_width    = r_out.width;
    assign dec_custom   = r_out.custom;
    assign dec_illegal  = r_out.illegal;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: one instance with custom opcodes enabled and
// a 16-bit counter, and one with custom opcodes disabled and a 3-bit counter.
module tb_decode_stage_pipe;

    localparam logic [31:0] ADDI1   = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] LW_X2   = 32'h0000A103; // lw x2,0(x1)
    localparam logic [31:0] ADD_321 = 32'h001101B3; // add x3,x2,x1
    localparam logic [31:0] LW_X0   = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] ADD_301 = 32'h001001B3; // add x3,x0,x1
    localparam logic [31:0] ADDI5   = 32'h00700293;
    localparam logic [31:0] ADDI6   = 32'h00900313;
    localparam logic [31:0] ADDI7   = 32'h00B00393;
    localparam logic [31:0] SUB     = 32'h402081B3; // sub x3,x1,x2
    localparam logic [31:0] BNE     = 32'h00209063; // bne x1,x2,0
    localparam logic [31:0] SB      = 32'h00208023; // sb x2,0(x1)
    localparam logic [31:0] JAL     = 32'h000000EF; // jal x1,0
    localparam logic [31:0] ILL     = 32'h0000007F;
    localparam logic [31:0] RAND    = 32'h0000022A; // custom random, rd=x4

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, ex_ready;
    logic [31:0] if_instr, if_pc;
    int          checks = 0;
    int          failures = 0;

    logic        if_ready, dec_valid, dec_write_en, dec_rd_en, dec_wrt_en, dec_jalr, dec_lui, dec_auipc, dec_illegal;
    logic [31:0] dec_pc, dec_instr;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [3:0]  dec_alu_op, dec_bj_inst;
    logic [1:0]  dec_wb_sel, dec_type_sel, dec_width;
    logic [7:0]  dec_custom;
    logic [15:0] stall_cnt;

    logic        nc_if_ready, nc_dec_valid, nc_write_en, nc_rd_en, nc_wrt_en, nc_jalr, nc_lui, nc_auipc, nc_illegal;
    logic [31:0] nc_pc, nc_instr;
    logic [4:0]  nc_rd, nc_rs1, nc_rs2;
    logic [3:0]  nc_alu_op, nc_bj_inst;
    logic [1:0]  nc_wb_sel, nc_type_sel, nc_width;
    logic [7:0]  nc_custom;
    logic [2:0]  nc_stall_cnt;

    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(32), .EN_CUSTOM(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready), .dec_valid(dec_valid), .dec_pc(dec_pc),
        .dec_instr(dec_instr), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_write_en(dec_write_en), .dec_rd_en(dec_rd_en), .dec_wrt_en(dec_wrt_en),
        .dec_jalr(dec_jalr), .dec_lui(dec_lui), .dec_auipc(dec_auipc), .dec_alu_op(dec_alu_op),
        .dec_bj_inst(dec_bj_inst), .dec_wb_sel(dec_wb_sel), .dec_type_sel(dec_type_sel),
        .dec_width(dec_width), .dec_custom(dec_custom), .dec_illegal(dec_illegal), .stall_cnt(stall_cnt)
    );

    decode_stage_pipe #(.XLEN(32), .EN_CUSTOM(0), .CNT_W(3)) dut_nc (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(nc_if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready), .dec_valid(nc_dec_valid), .dec_pc(nc_pc),
        .dec_instr(nc_instr), .dec_rd(nc_rd), .dec_rs1(nc_rs1), .dec_rs2(nc_rs2),
        .dec_write_en(nc_write_en), .dec_rd_en(nc_rd_en), .dec_wrt_en(nc_wrt_en),
        .dec_jalr(nc_jalr), .dec_lui(nc_lui), .dec_auipc(nc_auipc), .dec_alu_op(nc_alu_op),
        .dec_bj_inst(nc_bj_inst), .dec_wb_sel(nc_wb_sel), .dec_type_sel(nc_type_sel),
        .dec_width(nc_width), .dec_custom(nc_custom), .dec_illegal(nc_illegal), .stall_cnt(nc_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b1;

        // reset state
        tick(); #1;
        chk("rst_if_ready", 64'(if_ready), 64'd0);
        tick();
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_write_en", 64'(dec_write_en), 64'd0);
        chk("rst_illegal", 64'(dec_illegal), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_dec_pc", 64'(dec_pc), 64'd0);
        rst = 1'b0; #1;
        chk("idle_if_ready", 64'(if_ready), 64'd1);

        // single addi, one-cycle latency
        if_valid = 1'b1; if_instr = ADDI1; if_pc = 32'h100;
        tick(); if_valid = 1'b0; #1;
        chk("addi_valid", 64'(dec_valid), 64'd1);
        chk("addi_write_en", 64'(dec_write_en), 64'd1);
        chk("addi_alu_op", 64'(dec_alu_op), 64'd0);
        chk("addi_wb_sel", 64'(dec_wb_sel), 64'd3);
        chk("addi_rd", 64'(dec_rd), 64'd1);
        chk("addi_pc", 64'(dec_pc), 64'h100);
        tick();
        chk("addi_drained", 64'(dec_valid), 64'd0);

        // load-use hazard: one bubble
        if_valid = 1'b1; if_instr = LW_X2; if_pc = 32'h200;
        tick(); if_instr = ADD_321; if_pc = 32'h204; #1;
        chk("lu_if_ready_low", 64'(if_ready), 64'd0);
        chk("lu_ld_valid", 64'(dec_valid), 64'd1);
        chk("lu_ld_rd_en", 64'(dec_rd_en), 64'd1);
        chk("lu_ld_wb_sel", 64'(dec_wb_sel), 64'd2);
        tick(); #1;
        chk("lu_bubble", 64'(dec_valid), 64'd0);
        chk("lu_if_ready_back", 64'(if_ready), 64'd1);
        chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
        tick(); if_valid = 1'b0; #1;
        chk("lu_add_valid", 64'(dec_valid), 64'd1);
        chk("lu_add_instr", 64'(dec_instr), 64'(ADD_321));
        chk("lu_add_rs1", 64'(dec_rs1), 64'd2);
        chk("lu_add_rs2", 64'(dec_rs2), 64'd1);
        tick();

        // load to x0: no hazard
        if_valid = 1'b1; if_instr = LW_X0; if_pc = 32'h210;
        tick(); if_instr = ADD_301; if_pc = 32'h214; #1;
        chk("x0_if_ready", 64'(if_ready), 64'd1);
        tick(); if_valid = 1'b0; #1;
        chk("x0_add_valid", 64'(dec_valid), 64'd1);
        chk("x0_add_instr", 64'(dec_instr), 64'(ADD_301));
        chk("x0_stall_cnt", 64'(stall_cnt), 64'd1);
        tick();

        // output stall for three cycles: skid catches second fetch
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = ADDI5; if_pc = 32'h300;
        tick(); if_instr = ADDI6; if_pc = 32'h304; #1;
        chk("sk_ready_first", 64'(if_ready), 64'd1);
        tick(); if_instr = ADDI7; if_pc = 32'h308; #1;
        chk("sk_ready_drop", 64'(if_ready), 64'd0);
        chk("sk_hold_pc", 64'(dec_pc), 64'h300);
        tick(); #1;
        chk("sk_stable_pc", 64'(dec_pc), 64'h300);
        chk("sk_stable_valid", 64'(dec_valid), 64'd1);
        ex_ready = 1'b1;
        tick(); #1;
        chk("sk_second_pc", 64'(dec_pc), 64'h304);
        chk("sk_ready_back", 64'(if_ready), 64'd1);
        tick(); if_valid = 1'b0; #1;
        chk("sk_third_pc", 64'(dec_pc), 64'h308);
        chk("sk_third_instr", 64'(dec_instr), 64'(ADDI7));
        tick();
        chk("sk_empty", 64'(dec_valid), 64'd0);

        // flush with skid full and a fetch presented
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = ADDI5; if_pc = 32'h400;
        tick(); if_instr = ADDI6; if_pc = 32'h404;
        tick(); if_instr = ADDI7; if_pc = 32'h408; flush = 1'b1; #1;
        chk("fl_ready_full", 64'(if_ready), 64'd0);
        tick(); flush = 1'b0; if_valid = 1'b0; #1;
        chk("fl_dec_valid", 64'(dec_valid), 64'd0);
        chk("fl_if_ready", 64'(if_ready), 64'd1);
        ex_ready = 1'b1;
        tick();
        chk("fl_skid_gone", 64'(dec_valid), 64'd0);

        // decode table vectors, streamed back to back
        if_valid = 1'b1; if_instr = SUB; if_pc = 32'h600;
        tick(); if_instr = BNE; #1;
        chk("sub_alu_op", 64'(dec_alu_op), 64'd8);
        chk("sub_write_en", 64'(dec_write_en), 64'd1);
        tick(); if_instr = SB; #1;
        chk("bne_bj_inst", 64'(dec_bj_inst), 64'd9);
        chk("bne_type_sel", 64'(dec_type_sel), 64'd1);
        chk("bne_write_en", 64'(dec_write_en), 64'd0);
        tick(); if_instr = JAL; #1;
        chk("sb_width", 64'(dec_width), 64'd1);
        chk("sb_wrt_en", 64'(dec_wrt_en), 64'd1);
        chk("sb_write_en", 64'(dec_write_en), 64'd0);
        tick(); if_instr = ILL; #1;
        chk("jal_bj_inst", 64'(dec_bj_inst), 64'hB);
        chk("jal_type_sel", 64'(dec_type_sel), 64'd3);
        chk("jal_wb_sel", 64'(dec_wb_sel), 64'd1);
        tick(); if_instr = RAND; #1;
        chk("ill_illegal", 64'(dec_illegal), 64'd1);
        chk("ill_write_en", 64'(dec_write_en), 64'd0);
        chk("ill_custom", 64'(dec_custom), 64'd0);
        chk("nc_ill_illegal", 64'(nc_illegal), 64'd1);
        tick(); if_valid = 1'b0; #1;
        chk("rand_custom", 64'(dec_custom), 64'h80);
        chk("rand_illegal", 64'(dec_illegal), 64'd0);
        chk("rand_wb_sel", 64'(dec_wb_sel), 64'd2);
        chk("nc_rand_illegal", 64'(nc_illegal), 64'd1);
        chk("nc_rand_custom", 64'(nc_custom), 64'd0);
        chk("nc_rand_write_en", 64'(nc_write_en), 64'd0);
        tick();

        // held hazard: counter climbs, narrow counter saturates
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = LW_X2; if_pc = 32'h500;
        tick(); if_instr = ADD_321; if_pc = 32'h504;
        repeat (10) tick();
        chk("sat_stall_cnt", 64'(stall_cnt), 64'd11);
        chk("sat_nc_stall_cnt", 64'(nc_stall_cnt), 64'd7);
        chk("sat_hold_pc", 64'(dec_pc), 64'h500);
        chk("sat_if_ready", 64'(if_ready), 64'd0);

        // reset mid-stream
        rst = 1'b1; #1;
        chk("mrst_if_ready", 64'(if_ready), 64'd0);
        tick();
        chk("mrst_dec_valid", 64'(dec_valid), 64'd0);
        chk("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("mrst_dec_pc", 64'(dec_pc), 64'd0);
        chk("mrst_rd_en", 64'(dec_rd_en), 64'd0);
        rst = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
